// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR tap sequencer.
// Optional overrun counter is enabled with FIR_SEQ_OVR_CNT_EN.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RUN,
        DRAIN,
        DONE
    } fir_state_t;

    localparam int unsigned FIR_NBADD_DEF  = 8;
    localparam int unsigned FIR_TAPS_DEF   = 96;
    localparam int unsigned FIR_RD_LAT_DEF = 2;

    // Step a circular-buffer address one sample back in time, wrapping at taps.
    function automatic int unsigned addr_dec_mod(input int unsigned addr, input int unsigned taps);
        return (addr == 0) ? taps - 1 : addr - 1;
    endfunction

endpackage

// File: rtl/fir_valid_pipe.sv
// Tap-valid delay line matching the buffer/ROM read latency; output drives acc_en.
module fir_valid_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vld,
    output logic o_vld
);

    logic [DEPTH-1:0] r_vld_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= i_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
        end
    end

    assign o_vld = r_vld_p[DEPTH-1];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Control sequencer for a single-MAC FIR: sample write, tap stepping, accumulator strobes.
// Define FIR_SEQ_OVR_CNT_EN to add the saturating ovr_count output.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned NBADD  = FIR_NBADD_DEF,
    parameter int unsigned TAPS   = FIR_TAPS_DEF,
    parameter int unsigned RD_LAT = FIR_RD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             buf_we,
    output logic [NBADD-1:0] buf_addr,
    output logic [NBADD-1:0] coef_addr,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             out_valid,
    output logic             busy,
    input  logic             ovr_clr,
    output logic             overrun
`ifdef FIR_SEQ_OVR_CNT_EN
    ,
    output logic [7:0]       ovr_count
`endif
);

    localparam int unsigned CNTW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [NBADD-1:0] LAST_TAP = NBADD'(TAPS - 1);

    fir_state_t       r_state;
    logic             r_ready;
    logic             r_buf_we;
    logic [NBADD-1:0] r_buf_addr;
    logic [NBADD-1:0] r_coef_addr;
    logic             r_acc_clr;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_issue_p0;
    logic [NBADD-1:0] r_wp;
    logic [CNTW-1:0]  r_drain_cnt;
    logic             r_overrun;
    logic             w_drop;
    logic             w_acc_en;

    assign w_drop = sample_valid && !r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_buf_we    <= 1'b0;
            r_buf_addr  <= '0;
            r_coef_addr <= '0;
            r_acc_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_issue_p0  <= 1'b0;
            r_wp        <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (r_ready && sample_valid) begin
                        r_state    <= WRITE;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_buf_we   <= 1'b1;
                        r_buf_addr <= r_wp;
                        r_acc_clr  <= 1'b1;
                    end
                end
                WRITE: begin
                    r_buf_we    <= 1'b0;
                    r_acc_clr   <= 1'b0;
                    r_coef_addr <= '0;
                    r_buf_addr  <= r_wp;
                    r_issue_p0  <= 1'b1;
                    r_state     <= RUN;
                end
                RUN: begin
                    // Addresses hold their last value through DRAIN; only the pipe matters there.
                    if (r_coef_addr == LAST_TAP) begin
                        r_issue_p0  <= 1'b0;
                        r_drain_cnt <= '0;
                        r_state     <= DRAIN;
                    end else begin
                        r_coef_addr <= r_coef_addr + NBADD'(1);
                        r_buf_addr  <= NBADD'(addr_dec_mod(32'(r_buf_addr), TAPS));
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == CNTW'(RD_LAT - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CNTW'(1);
                    end
                end
                DONE: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_ready     <= 1'b1;
                    r_wp        <= (r_wp == LAST_TAP) ? '0 : r_wp + NBADD'(1);
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef FIR_SEQ_OVR_CNT_EN
    logic [7:0] r_ovr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_count <= 8'd0;
        end else if (w_drop) begin
            if (ovr_clr) begin
                r_ovr_count <= 8'd1;
            end else if (r_ovr_count != 8'hFF) begin
                r_ovr_count <= r_ovr_count + 8'd1;
            end
        end else if (ovr_clr) begin
            r_ovr_count <= 8'd0;
        end
    end

    assign ovr_count = r_ovr_count;
`endif

    fir_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (r_issue_p0),
        .o_vld (w_acc_en)
    );

    assign sample_ready = r_ready;
    assign buf_we       = r_buf_we;
    assign buf_addr     = r_buf_addr;
    assign coef_addr    = r_coef_addr;
    assign acc_clr      = r_acc_clr;
    assign acc_en       = w_acc_en;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer (TAPS=96, RD_LAT=2); FIR_SEQ_OVR_CNT_EN adds counter checks.
module tb_fir_tap_sequencer;

    localparam int NBADD  = 8;
    localparam int TAPS   = 96;
    localparam int RD_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sample_valid;
    logic             sample_ready;
    logic             buf_we;
    logic [NBADD-1:0] buf_addr;
    logic [NBADD-1:0] coef_addr;
    logic             acc_clr;
    logic             acc_en;
    logic             out_valid;
    logic             busy;
    logic             ovr_clr;
    logic             overrun;
`ifdef FIR_SEQ_OVR_CNT_EN
    logic [7:0]       ovr_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    fir_tap_sequencer #(
        .NBADD  (NBADD),
        .TAPS   (TAPS),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .buf_we       (buf_we),
        .buf_addr     (buf_addr),
        .coef_addr    (coef_addr),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .out_valid    (out_valid),
        .busy         (busy),
        .ovr_clr      (ovr_clr),
        .overrun      (overrun)
`ifdef FIR_SEQ_OVR_CNT_EN
        ,
        .ovr_count    (ovr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observe one cycle: values just after the rising edge has updated the registers.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!sample_ready && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, sample_ready, 1);
    endtask

    task automatic run_one(input int exp_wp, input bit detail);
        int n_en = 0, first_en = -1, last_en = -1, n_ov = 0, ov_cyc = -1, busy_lo = -1, bad = 0;
        int seq [0:TAPS-1];
        wait_ready("run");
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("w_buf_we", buf_we, 1);
        chk("w_buf_addr", buf_addr, exp_wp);
        chk("w_acc_clr", acc_clr, 1);
        chk("w_busy", busy, 1);
        chk("w_ready", sample_ready, 0);
        for (int c = 2; c <= 110; c++) begin
            step();
            if (acc_en) begin
                n_en++;
                if (first_en < 0) first_en = c;
                last_en = c;
            end
            if (out_valid) begin
                n_ov++;
                ov_cyc = c;
            end
            if (!busy && busy_lo < 0) busy_lo = c;
            if (c >= 2 && c <= TAPS + 1) begin
                if (int'(coef_addr) != c - 2) bad++;
                if (int'(buf_addr) != (exp_wp - (c - 2) + TAPS) % TAPS) bad++;
                seq[c-2] = int'(buf_addr);
            end
        end
        chk("acc_en_count", n_en, 96);
        chk("acc_en_first", first_en, 4);
        chk("acc_en_last", last_en, 99);
        chk("out_valid_count", n_ov, 1);
        chk("out_valid_cycle", ov_cyc, 100);
        chk("busy_low_cycle", busy_lo, 101);
        chk("run_addr_errs", bad, 0);
        if (detail) begin
            chk("seq_k0", seq[0], 5);
            chk("seq_k5", seq[5], 0);
            chk("seq_k6", seq[6], 95);
            chk("seq_k95", seq[95], 6);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        ovr_clr      = 1'b0;
        repeat (3) step();
        chk("rst_ready", sample_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_coef_addr", coef_addr, 0);
`ifdef FIR_SEQ_OVR_CNT_EN
        chk("rst_ovr_count", ovr_count, 0);
`endif
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", sample_ready, 1);

        // Walk wp from 0 to 5; the wp=5 run also checks the wrap-around order.
        for (int w = 0; w <= 5; w++) run_one(w, w == 5);

        // 97 samples at the minimum period, starting from wp=6.
        begin
            int sent = 0, nov = 0, nwr = 0, bad_addr = 0, bad_per = 0, cyc = 0, last_wr = -1;
            while (nov < 97 && cyc < 97 * 101 + 300) begin
                if (sample_ready && sent < 97) begin
                    sample_valid = 1'b1;
                    sent++;
                end else begin
                    sample_valid = 1'b0;
                end
                step();
                cyc++;
                if (buf_we) begin
                    if (int'(buf_addr) != (6 + nwr) % TAPS) bad_addr++;
                    if (last_wr >= 0 && cyc - last_wr != 101) bad_per++;
                    last_wr = cyc;
                    nwr++;
                end
                if (out_valid) nov++;
            end
            sample_valid = 1'b0;
            chk("b2b_out_valid", nov, 97);
            chk("b2b_writes", nwr, 97);
            chk("b2b_wr_addr_errs", bad_addr, 0);
            chk("b2b_period_errs", bad_per, 0);
            chk("b2b_overrun", overrun, 0);
        end

        // Drop at cycle 50, then a drop coinciding with ovr_clr; wp is now 7.
        begin
            int nov = 0, n = 0;
            wait_ready("ovr");
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            chk("ovr_wr_addr", buf_addr, 7);
            repeat (48) step();
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            chk("ovr_flag", overrun, 1);
`ifdef FIR_SEQ_OVR_CNT_EN
            chk("ovr_count_1", ovr_count, 1);
`endif
            repeat (9) step();
            sample_valid = 1'b1;
            ovr_clr      = 1'b1;
            step();
            sample_valid = 1'b0;
            ovr_clr      = 1'b0;
            chk("ovr_clr_set_wins", overrun, 1);
`ifdef FIR_SEQ_OVR_CNT_EN
            chk("ovr_count_clr_drop", ovr_count, 1);
`endif
            ovr_clr = 1'b1;
            step();
            ovr_clr = 1'b0;
            chk("ovr_cleared", overrun, 0);
`ifdef FIR_SEQ_OVR_CNT_EN
            chk("ovr_count_cleared", ovr_count, 0);
`endif
            while (busy && n < 200) begin
                step();
                n++;
                if (out_valid) nov++;
            end
            chk("ovr_run_out_valid", nov, 1);
        end

        // Reset while RUN is at tap 40.
        begin
            int n = 0, nov = 0, nen = 0;
            wait_ready("mid_rst");
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            while (coef_addr != 8'd40 && n < 200) begin
                step();
                n++;
            end
            chk("mid_rst_reach_k40", coef_addr, 40);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_ready", sample_ready, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_acc_en", acc_en, 0);
            chk("mid_rst_acc_clr", acc_clr, 0);
            chk("mid_rst_buf_we", buf_we, 0);
            chk("mid_rst_out_valid", out_valid, 0);
            chk("mid_rst_buf_addr", buf_addr, 0);
            chk("mid_rst_coef_addr", coef_addr, 0);
            step();
            step();
            rst_n = 1'b1;
            for (int c = 0; c < 120; c++) begin
                step();
                if (out_valid) nov++;
                if (acc_en) nen++;
            end
            chk("mid_rst_no_out_valid", nov, 0);
            chk("mid_rst_no_acc_en", nen, 0);
            run_one(0, 1'b0);
        end

        // Hold sample_valid high: most samples are dropped while busy.
        sample_valid = 1'b1;
        repeat (350) step();
        sample_valid = 1'b0;
        chk("sat_overrun", overrun, 1);
`ifdef FIR_SEQ_OVR_CNT_EN
        chk("sat_ovr_count", ovr_count, 255);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("sat_ovr_count_clr", ovr_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
